// File: rtl/timer_irq_responder_pkg.sv
// Shared types for the Frost32 memory-mapped timer responder.
// Bus bundles, access enums, FSM states and register map.
package PkgTimerIrq;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_type_t;

    typedef enum logic [1:0] {
        ACC_SZ_32 = 2'b00,
        ACC_SZ_16 = 2'b01,
        ACC_SZ_8  = 2'b10
    } acc_size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    // Word index within the 16-byte window (addr[3:2]).
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_RELOAD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_AUTO_BIT   = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        acc_type_t   data_inout_access_type;
        acc_size_t   data_inout_access_size;
        logic        req_mem_access;
    } PortIn_TimerIrq;

    typedef struct packed {
        logic [31:0] data;
        logic        wait_for_mem;
        logic        interrupt;
    } PortOut_TimerIrq;

    function automatic logic is_legal(acc_size_t sz, logic [1:0] lo);
        return (sz == ACC_SZ_32) && (lo == 2'b00);
    endfunction

endpackage

// File: rtl/timer_irq_responder_counter.sv
// Down-counter core: CTRL bits, RELOAD, COUNT, pending and the
// registered interrupt level, updated from bus write strobes.
module timer_irq_counter
    import PkgTimerIrq::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_we,
    input  logic        reload_we,
    input  logic        status_w1c,
    input  logic [31:0] wdata,
    output logic        en,
    output logic        irq_en,
    output logic        auto_reload,
    output logic [31:0] count,
    output logic [31:0] reload,
    output logic        pending,
    output logic        irq
);

    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        auto_q, auto_d;
    logic [31:0] count_q, count_d;
    logic [31:0] reload_q, reload_d;
    logic        pending_q, pending_d;
    logic        irq_q, irq_d;
    logic        expire;

    always_comb begin
        expire    = en_q && (count_q == 32'd0);
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        auto_d    = auto_q;
        count_d   = count_q;
        reload_d  = reload_q;
        pending_d = pending_q;
        irq_d     = pending_q & irq_en_q;

        if (expire) begin
            pending_d = 1'b1;
            if (auto_q) count_d = reload_q;
            else        en_d    = 1'b0;
        end else if (en_q) begin
            count_d = count_q - 32'd1;
        end

        // Software writes override the hardware update, except that
        // a same-edge expiry beats the W1C.
        if (status_w1c && !expire) pending_d = 1'b0;
        if (reload_we) begin
            reload_d = wdata;
            count_d  = wdata;
        end
        if (ctrl_we) begin
            en_d     = wdata[CTRL_EN_BIT];
            irq_en_d = wdata[CTRL_IRQ_EN_BIT];
            auto_d   = wdata[CTRL_AUTO_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            auto_q    <= 1'b0;
            count_q   <= 32'd0;
            reload_q  <= 32'd0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            auto_q    <= auto_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign en          = en_q;
    assign irq_en      = irq_en_q;
    assign auto_reload = auto_q;
    assign count       = count_q;
    assign reload      = reload_q;
    assign pending     = pending_q;
    assign irq         = irq_q;

endmodule

// File: rtl/timer_irq_responder.sv
// Frost32 bus responder for the down-counting timer: a 3-state
// access FSM in front of the counter core.
module timer_irq_responder
    import PkgTimerIrq::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  PortIn_TimerIrq  in,
    output PortOut_TimerIrq out
);

    state_t      state_q, state_d;
    logic [1:0]  reg_q, reg_d;
    logic        legal_q, legal_d;
    acc_type_t   type_q, type_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        hit;
    logic        ctrl_we, reload_we, status_w1c;
    logic        en, irq_en, auto_reload, pending, irq;
    logic [31:0] count, reload;

    assign hit = in.addr[31:4] == BASE_ADDR[31:4];

    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        legal_d    = legal_q;
        type_d     = type_q;
        wdata_d    = wdata_q;
        rdata_d    = 32'd0;
        ctrl_we    = 1'b0;
        reload_we  = 1'b0;
        status_w1c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in.req_mem_access && hit) begin
                    reg_d   = in.addr[3:2];
                    legal_d = is_legal(in.data_inout_access_size,
                                       in.addr[1:0]);
                    type_d  = in.data_inout_access_type;
                    wdata_d = in.data;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                if (legal_q && type_q == ACC_WRITE) begin
                    ctrl_we    = reg_q == REG_CTRL;
                    reload_we  = reg_q == REG_RELOAD;
                    status_w1c = (reg_q == REG_STATUS) && wdata_q[0];
                end else if (legal_q) begin
                    unique case (reg_q)
                        REG_CTRL:   rdata_d = {29'd0, auto_reload,
                                               irq_en, en};
                        REG_RELOAD: rdata_d = reload;
                        REG_COUNT:  rdata_d = count;
                        REG_STATUS: rdata_d = {31'd0, pending};
                    endcase
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            reg_q   <= 2'd0;
            legal_q <= 1'b0;
            type_q  <= ACC_READ;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            legal_q <= legal_d;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    timer_irq_counter u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_we     (ctrl_we),
        .reload_we   (reload_we),
        .status_w1c  (status_w1c),
        .wdata       (wdata_q),
        .en          (en),
        .irq_en      (irq_en),
        .auto_reload (auto_reload),
        .count       (count),
        .reload      (reload),
        .pending     (pending),
        .irq         (irq)
    );

    // rdata_q is only non-zero during DONE after a legal read.
    always_comb begin
        out.data         = rdata_q;
        out.wait_for_mem = state_q == ST_ACCESS;
        out.interrupt    = irq;
    end

endmodule

// File: tb/tb_timer_irq_responder.sv
// Bench for timer_irq_responder: vector table, corner sequences,
// and random bus traffic against a register-level timer model.
module tb_timer_irq_responder;
    import PkgTimerIrq::*;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    PortIn_TimerIrq  din;
    PortOut_TimerIrq dout;

    timer_irq_responder #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (din),
        .out   (dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        irq_en;
        logic        auto_rl;
        logic [31:0] reload;
        logic [31:0] count;
        logic        pending;
        logic        irq;
    } model_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        acc_type_t   t;
        acc_size_t   s;
        logic [31:0] exp;
    } vec_t;

    model_t      m;
    logic        mw_ctrl = 1'b0;
    logic        mw_reload = 1'b0;
    logic        mw_w1c = 1'b0;
    logic [31:0] mw_data = 32'd0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        chk_irq = 1'b0;

    // One clock of timer behaviour, software write applied last.
    function automatic model_t model_next(model_t c, logic wc, logic wr,
                                          logic w1c, logic [31:0] wd);
        model_t n = c;
        logic expire = c.en && (c.count == 32'd0);
        n.irq = c.pending && c.irq_en;
        if (expire) begin
            n.pending = 1'b1;
            if (c.auto_rl) n.count = c.reload;
            else           n.en = 1'b0;
        end else if (c.en) begin
            n.count = c.count - 32'd1;
        end
        if (w1c && !expire) n.pending = 1'b0;
        if (wr) begin
            n.reload = wd;
            n.count  = wd;
        end
        if (wc) begin
            n.en      = wd[0];
            n.irq_en  = wd[1];
            n.auto_rl = wd[2];
        end
        return n;
    endfunction

    function automatic logic [31:0] model_read(logic [1:0] r);
        case (r)
            2'd0:    return {29'd0, m.auto_rl, m.irq_en, m.en};
            2'd1:    return m.reload;
            2'd2:    return m.count;
            default: return {31'd0, m.pending};
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) m <= '0;
        else m <= model_next(m, mw_ctrl, mw_reload, mw_w1c, mw_data);
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, want %h",
                     name, cyc, got, exp);
        end
    endtask

    always @(negedge clk)
        if (chk_irq) check("irq", 32'(dout.interrupt), 32'(m.irq));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input acc_type_t t, input acc_size_t s,
                          output logic [31:0] rd, output int commit);
        logic        hit = a[31:4] == BASE[31:4];
        logic        legal = (s == ACC_SZ_32) && (a[1:0] == 2'b00);
        logic [31:0] exp = 32'd0;
        din.addr = a;
        din.data = d;
        din.data_inout_access_type = t;
        din.data_inout_access_size = s;
        din.req_mem_access = 1'b1;
        step(1);
        din.req_mem_access = 1'b0;
        check("wait_access", 32'(dout.wait_for_mem), 32'(hit));
        check("data_access", dout.data, 32'd0);
        if (hit && legal) begin
            if (t == ACC_READ) begin
                exp = model_read(a[3:2]);
            end else begin
                mw_data   = d;
                mw_ctrl   = a[3:2] == 2'd0;
                mw_reload = a[3:2] == 2'd1;
                mw_w1c    = (a[3:2] == 2'd3) && d[0];
            end
        end
        step(1);
        commit = cyc;
        mw_ctrl = 1'b0;
        mw_reload = 1'b0;
        mw_w1c = 1'b0;
        check("wait_done", 32'(dout.wait_for_mem), 32'd0);
        check("data_done", dout.data, exp);
        rd = dout.data;
        step(1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      output int commit);
        logic [31:0] rd;
        access(a, d, ACC_WRITE, ACC_SZ_32, rd, commit);
    endtask

    task automatic rdr(input logic [31:0] a, output logic [31:0] rd);
        int c;
        access(a, 32'd0, ACC_READ, ACC_SZ_32, rd, c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[18];
        logic [31:0] rd, prev;
        int          c, ce, k;

        tbl[0]  = '{BASE + 12, 32'd0, ACC_READ, ACC_SZ_32, 32'd0};
        tbl[1]  = '{BASE + 0, 32'd0, ACC_READ, ACC_SZ_32, 32'd0};
        tbl[2]  = '{BASE + 4, 32'h1234_5678, ACC_WRITE, ACC_SZ_32, 32'd0};
        tbl[3]  = '{BASE + 4, 32'd0, ACC_READ, ACC_SZ_32, 32'h1234_5678};
        tbl[4]  = '{BASE + 8, 32'd0, ACC_READ, ACC_SZ_32, 32'h1234_5678};
        tbl[5]  = '{BASE + 0, 32'hFFFF_FFF6, ACC_WRITE, ACC_SZ_32, 32'd0};
        tbl[6]  = '{BASE + 0, 32'd0, ACC_READ, ACC_SZ_32, 32'd6};
        tbl[7]  = '{BASE + 8, 32'h55, ACC_WRITE, ACC_SZ_32, 32'd0};
        tbl[8]  = '{BASE + 8, 32'd0, ACC_READ, ACC_SZ_32, 32'h1234_5678};
        tbl[9]  = '{BASE + 4, 32'hDEAD, ACC_WRITE, ACC_SZ_8, 32'd0};
        tbl[10] = '{BASE + 5, 32'hBEEF, ACC_WRITE, ACC_SZ_32, 32'd0};
        tbl[11] = '{BASE + 4, 32'd0, ACC_READ, ACC_SZ_32, 32'h1234_5678};
        tbl[12] = '{BASE + 8, 32'd0, ACC_READ, ACC_SZ_32, 32'h1234_5678};
        tbl[13] = '{BASE + 4, 32'd0, ACC_READ, ACC_SZ_16, 32'd0};
        tbl[14] = '{BASE + 6, 32'd0, ACC_READ, ACC_SZ_32, 32'd0};
        tbl[15] = '{32'h0002_0000, 32'd0, ACC_READ, ACC_SZ_32, 32'd0};
        tbl[16] = '{BASE + 0, 32'd0, ACC_WRITE, ACC_SZ_32, 32'd0};
        tbl[17] = '{BASE + 0, 32'd0, ACC_READ, ACC_SZ_32, 32'd0};

        din = '0;
        rst_n = 1'b0;
        step(3);
        check("rst_wait", 32'(dout.wait_for_mem), 32'd0);
        check("rst_data", dout.data, 32'd0);
        check("rst_irq", 32'(dout.interrupt), 32'd0);
        rst_n = 1'b1;
        chk_irq = 1'b1;

        for (int i = 0; i < 18; i++) begin
            access(tbl[i].addr, tbl[i].data, tbl[i].t, tbl[i].s, rd, c);
            if (tbl[i].t == ACC_READ) check($sformatf("tbl%0d", i),
                                            rd, tbl[i].exp);
        end

        // One-shot: RELOAD=5, CTRL=3 -> interrupt 7 edges later.
        wr(BASE + 4, 32'd5, c);
        wr(BASE + 0, 32'd3, ce);
        k = 0;
        while (!dout.interrupt && k < 50) begin
            step(1);
            k++;
        end
        check("irq_delay", 32'(cyc - ce), 32'd7);
        rdr(BASE + 0, rd);
        check("en_selfclear", rd, 32'd2);
        rdr(BASE + 8, rd);
        check("oneshot_count", rd, 32'd0);
        wr(BASE + 12, 32'd1, c);
        rdr(BASE + 12, rd);
        check("w1c_clear", rd, 32'd0);

        // Auto-reload period 3; W1C on and off an expiry edge.
        wr(BASE + 4, 32'd2, c);
        wr(BASE + 0, 32'd7, c);
        k = 0;
        while (m.count != 32'd1 && k < 20) begin
            step(1);
            k++;
        end
        wr(BASE + 12, 32'd1, c);
        rdr(BASE + 12, rd);
        check("w1c_vs_set", rd, 32'd1);
        k = 0;
        while (m.count != 32'd2 && k < 20) begin
            step(1);
            k++;
        end
        wr(BASE + 12, 32'd1, c);
        check("irq_gap", 32'(dout.interrupt), 32'd0);
        step(1);
        check("irq_reset", 32'(dout.interrupt), 32'd1);
        wr(BASE + 0, 32'd0, c);
        wr(BASE + 12, 32'd1, c);

        // COUNT readback while counting down from 100.
        wr(BASE + 4, 32'd100, c);
        wr(BASE + 0, 32'd1, ce);
        prev = 32'd101;
        for (int i = 0; i < 6; i++) begin
            step($urandom_range(0, 5));
            access(BASE + 8, 32'd0, ACC_READ, ACC_SZ_32, rd, c);
            check("count_rd", rd, 32'd100 - 32'(c - 1 - ce));
            check("count_mono", 32'(rd < prev), 32'd1);
            prev = rd;
        end
        wr(BASE + 0, 32'd0, c);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, d;
            acc_type_t   t;
            acc_size_t   s;
            if ($urandom_range(0, 9) < 8) begin
                a = BASE | 32'($urandom_range(0, 3) * 4);
                if ($urandom_range(0, 7) == 0)
                    a[1:0] = 2'($urandom_range(1, 3));
            end else begin
                a = $urandom;
                if (a[31:4] == BASE[31:4]) a[8] = ~a[8];
            end
            d = ($urandom_range(0, 7) == 0) ? $urandom
                                             : 32'($urandom_range(0, 12));
            t = ($urandom_range(0, 1) == 1) ? ACC_WRITE : ACC_READ;
            s = ($urandom_range(0, 7) == 0)
                ? acc_size_t'(2'($urandom_range(1, 2))) : ACC_SZ_32;
            access(a, d, t, s, rd, c);
            step($urandom_range(0, 2));
        end

        // Reset during ACCESS of a RELOAD write aborts it.
        wr(BASE + 4, 32'd0, c);
        wr(BASE + 0, 32'd7, c);
        step(3);
        check("pre_rst_irq", 32'(dout.interrupt), 32'd1);
        din.addr = BASE + 4;
        din.data = 32'h77;
        din.data_inout_access_type = ACC_WRITE;
        din.data_inout_access_size = ACC_SZ_32;
        din.req_mem_access = 1'b1;
        step(1);
        din.req_mem_access = 1'b0;
        check("abort_wait_hi", 32'(dout.wait_for_mem), 32'd1);
        rst_n = 1'b0;
        step(1);
        check("abort_wait_lo", 32'(dout.wait_for_mem), 32'd0);
        check("abort_data", dout.data, 32'd0);
        check("abort_irq", 32'(dout.interrupt), 32'd0);
        rst_n = 1'b1;
        rdr(BASE + 4, rd);
        check("abort_reload", rd, 32'd0);
        rdr(BASE + 0, rd);
        check("abort_ctrl", rd, 32'd0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
